// File: rtl/tribus_ctrl.sv
// rtl/tribus_ctrl.sv - round-robin arbiter for a 4-driver shared tri-state bus with turnaround
// Optional macro: TRIBUS_STATS_EN adds the xfer_cnt transfer counter output.
module tribus_ctrl #(
    parameter int WIDTH = 8,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] bus_in,
    output logic [3:0]       en,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [1:0]       rx_src,
    output logic             busy
`ifdef TRIBUS_STATS_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    localparam logic [2:0] TURN_LAST = 3'(TURN - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr, r_win, w_win_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       r_en, w_en_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_rx_valid, w_cap;
    logic [WIDTH-1:0] r_rx_data;
    logic [1:0]       r_rx_src;
    logic [1:0]       w_rr_win, w_idx;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        w_rr_win = r_ptr;
        w_idx    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) w_rr_win = w_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_DRIVE;
                    w_en_nxt    = 4'b0001 << w_rr_win;
                    w_busy_nxt  = 1'b1;
                    w_win_nxt   = w_rr_win;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_TURN;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = 3'd0;
                w_cap       = 1'b1;
            end
            S_TURN: begin
                if (r_cnt == TURN_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt + 3'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_win      <= 2'd0;
            r_cnt      <= 3'd0;
            r_en       <= 4'b0000;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_src   <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_win      <= w_win_nxt;
            r_cnt      <= w_cnt_nxt;
            r_en       <= w_en_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_valid <= w_cap;
            if (w_cap) begin
                r_rx_data <= bus_in;
                r_rx_src  <= r_win;
                r_ptr     <= r_win + 2'd1;
            end
        end
    end

`ifdef TRIBUS_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_xfer_cnt <= 16'd0;
        else if (w_cap) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

    assign en       = r_en;
    assign busy     = r_busy;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign rx_src   = r_rx_src;

endmodule

// File: tb/tb_tribus_ctrl.sv
// tb/tb_tribus_ctrl.sv - directed scoreboard bench for tribus_ctrl (TURN=1 and TURN=3 instances)
module tb_tribus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req3;
    logic [7:0] bus_in, bus_in3;
    logic [3:0] en, en3;
    logic [7:0] rx_data, rx_data3;
    logic       rx_valid, rx_valid3;
    logic [1:0] rx_src, rx_src3;
    logic       busy, busy3;
`ifdef TRIBUS_STATS_EN
    logic [15:0] xfer_cnt, xfer_cnt3;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;
    int n_done3 = 0;
    int prev;
    logic [9:0] sb[$];
    logic [7:0] drv[4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

    always #5 clk = ~clk;

    always_comb begin
        bus_in = 8'h00;
        for (int i = 0; i < 4; i++) if (en[i]) bus_in = drv[i];
        if ($countones(en) > 1) bus_in = 'x;
    end
    assign bus_in3 = en3[0] ? 8'h77 : 8'h00;

    tribus_ctrl #(.WIDTH(8), .TURN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .bus_in(bus_in), .en(en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_src(rx_src), .busy(busy)
`ifdef TRIBUS_STATS_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    tribus_ctrl #(.WIDTH(8), .TURN(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .bus_in(bus_in3), .en(en3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_src(rx_src3), .busy(busy3)
`ifdef TRIBUS_STATS_EN
        , .xfer_cnt(xfer_cnt3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and run the per-cycle monitor/scoreboard.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            check("en_onehot", 32'($countones(en) <= 1), 32'd1);
            check("en3_onehot", 32'($countones(en3) <= 1), 32'd1);
            if (rx_valid) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("rx_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rx_src", 32'(rx_src), 32'(e[9:8]));
                    check("rx_data", 32'(rx_data), 32'(e[7:0]));
                end
            end
            if (rx_valid3) begin
                n_done3++;
                check("rx3_src", 32'(rx_src3), 32'd0);
                check("rx3_data", 32'(rx_data3), 32'h77);
            end
        end
    endtask

    task automatic grant(input int src, input bit push);
        int k = 0;
        if (push) sb.push_back({2'(src), drv[src]});
        do begin
            tick();
            k++;
        end while (en == 4'b0000 && k < 10);
        check($sformatf("grant_%0d", src), 32'(en), 32'(4'b0001 << src));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        req3 = 4'b0000;
        tick();
        tick();
        check("reset_en", 32'(en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_src", 32'(rx_src), 32'd0);
        rst = 1'b0;

        // single request from driver 0
        req = 4'b0001;
        grant(0, 1'b1);
        check("busy_drive", 32'(busy), 32'd1);
        req = 4'b0000;
        tick();
        check("rx_valid_pulse", 32'(rx_valid), 32'd1);
        check("rx_data_a5", 32'(rx_data), 32'hA5);
        check("busy_turn", 32'(busy), 32'd1);
        tick();
        check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
        check("rx_data_hold", 32'(rx_data), 32'hA5);
        check("busy_idle", 32'(busy), 32'd0);

        // all requesting from a fresh reset: 0,1,2,3 at 3-cycle spacing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            grant(i, 1'b1);
            if (i > 0) check("grant_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
        end
        req = 4'b0000;
        tick();
        tick();

        // wrap from ptr=3, then a requester that withdraws before IDLE
        req = 4'b0100;
        grant(2, 1'b1);
        req = 4'b0101;
        grant(0, 1'b1);
        grant(2, 1'b1);
        req = 4'b1000;
        tick();
        req = 4'b0010;
        grant(1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // reset mid-DRIVE releases the bus immediately and drops the slot
        req = 4'b0010;
        grant(1, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_en", 32'(en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        check("abort_rx_data", 32'(rx_data), 32'd0);
        check("abort_rx_src", 32'(rx_src), 32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        grant(1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // TURN=3 instance, continuous request from driver 0
        req3 = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("t3_en_%0d", k), 32'(en3), (k % 5 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_busy_%0d", k), 32'(busy3), (k % 5 == 4) ? 32'd0 : 32'd1);
        end
        req3 = 4'b0000;
        for (int k = 0; k < 6; k++) tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("t3_slots", 32'(n_done3), 32'd3);
`ifdef TRIBUS_STATS_EN
        check("xfer_cnt", 32'(xfer_cnt), 32'(n_done));
        check("xfer_cnt3", 32'(xfer_cnt3), 32'd3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tribus_ctrl.md
TRIBUS_CTRL -- requirements
Module: tribus_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of the shared tri-state data bus.
REQ-002 Parameter: TURN, 1, number of idle turnaround cycles after each drive slot (legal 1..7).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req  input  4  per-driver request; bit i set = driver i has a word to place on the bus.
REQ-006 Port: bus_in  input  WIDTH  resolved value of the shared bus, sampled by this block.
REQ-007 Port: en  output  4  one-hot drive enables, one per bufif1 bank; all-zero = bus released (z).
REQ-008 Port: rx_data  output  WIDTH  word captured from bus_in at the end of a drive slot.
REQ-009 Port: rx_valid  output  1  one-cycle pulse; rx_data/rx_src valid.
REQ-010 Port: rx_src  output  2  index of the driver that produced rx_data.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, TURN; en and busy SHALL be registered outputs.
REQ-013 IDLE: if any req bit set, SHALL pick winner by round-robin starting at ptr, set en to one-hot winner, go to DRIVE next cycle.
REQ-014 IDLE with req==0: SHALL stay IDLE, en=0.
REQ-015 DRIVE SHALL last exactly one cycle; en SHALL hold the winner's one-hot code for that whole cycle.
REQ-016 On the edge leaving DRIVE: rx_data<=bus_in, rx_src<=winner, rx_valid<=1, en<=0, ptr<=winner+1 (mod 4), go to TURN.
REQ-017 rx_valid SHALL be high for exactly one cycle per drive slot; rx_data and rx_src SHALL hold until the next capture.
REQ-018 TURN SHALL last exactly TURN cycles with en=0, then go to IDLE; at most one bit of en SHALL ever be set (no bus contention by construction).
REQ-019 Grant-to-grant minimum spacing SHALL be 2+TURN cycles (IDLE, DRIVE, TURN...).
REQ-020 req changes during DRIVE or TURN SHALL NOT affect the current slot; req is re-evaluated only in IDLE.
REQ-021 Simultaneous requests: winner SHALL be first set bit at or after ptr, wrapping 3->0.
REQ-022 A requester deasserting req before being granted SHALL simply lose eligibility; no grant is issued for it.
REQ-023 busy SHALL be high in DRIVE and TURN, low in IDLE.

Reset
REQ-024 On rst high, asynchronously: state=IDLE, en=0, ptr=0, rx_data=0, rx_src=0, rx_valid=0, busy=0, turnaround counter=0.
REQ-025 Reset asserted mid-DRIVE SHALL release the bus (en=0) immediately without waiting for a clock; no rx_valid pulse for the aborted slot.
REQ-026 First arbitration after reset release SHALL start at driver 0.

Configuration
REQ-027 Macro TRIBUS_STATS_EN: when defined, SHALL add output xfer_cnt [15:0], reset to 0, incremented on every rx_valid pulse, wrapping 0xFFFF->0x0000.
REQ-028 Without TRIBUS_STATS_EN, port xfer_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset then req=4'b0001, driver 0 drives bus_in=8'hA5 while en[0]=1 -> en=0001 for one cycle, next cycle rx_valid=1, rx_data=A5, rx_src=0.
REQ-030 req=4'b1111 held for 4 slots with TURN=1 -> grants in order 0,1,2,3, each rx_valid 3 cycles apart, en never multi-hot.
REQ-031 Grant to driver 2, then req=4'b0101 -> next grant is driver 0 (wrap from ptr=3), then driver 2.
REQ-032 Assert rst during DRIVE of driver 1 -> en=0 same cycle, no rx_valid, after release req=4'b0010 is granted first.
REQ-033 TURN=3, req=4'b0001 continuously -> en[0] high one cycle in every 5, busy low exactly one cycle between slots.
REQ-034 With TRIBUS_STATS_EN, 3 completed slots -> xfer_cnt=3; preload to 0xFFFF then one slot -> xfer_cnt=0.
